half_fp_round_pack: RTL and testbench
=====================================

HALF_FP_ROUND_PACK -- requirements
Module: half_fp_round_pack

Interface
REQ-001 SHALL have these ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous active-low reset
- in_valid  in  1  upstream product valid
- in_ready  out  1  block can accept a product
- in_sign  in  1  product sign
- in_exp  in  7  signed two's-complement biased exponent: eff_exp1 + eff_exp2 - 15, subnormal operand counted as 1
- in_mant  in  22  raw {hidden,mant1}*{hidden,mant2}; binary point between bits 20 and 19
- in_special  in  1  upstream resolved inf/NaN/zero; bypass rounding
- in_special_val  in  16  packed result when in_special=1
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  16  packed IEEE-754 binary16
- flag_overflow  out  1  result overflowed to infinity
- flag_underflow  out  1  tiny and inexact result
- flag_inexact  out  1  rounding discarded nonzero bits

Function
REQ-002 SHALL implement FSM states IDLE, NORM, DENORM, ROUND, DONE.
REQ-003 SHALL assert in_ready only in IDLE; a transfer occurs on in_valid & in_ready, capturing all in_* fields.
REQ-004 SHALL, on an in_special capture, go to DONE next cycle with result=in_special_val and all flags 0 (out_valid 1 cycle after the transfer).
REQ-005 SHALL, on a normal capture, go to NORM; if in_mant==0, go to DONE with result = signed zero and no flags.
REQ-006 SHALL in NORM, once per cycle: if mant[21]=1, shift right 1, sticky|=shifted bit, exp+=1; else if mant[20]=0 and exp>1, shift left 1, exp-=1; otherwise exit to DENORM if exp<1, else to ROUND.
REQ-007 SHALL in DENORM, once per cycle: shift right 1, sticky|=shifted bit, exp+=1, until exp==1, then go to ROUND; if exp<=-12 on entry, set mant=0, sticky=OR(mant), exp=1 in one cycle.
REQ-008 SHALL in ROUND apply round-to-nearest-even: frac=mant[19:10], G=mant[9], S=|mant[8:0] | sticky; increment when G & (S | frac[0]).
REQ-009 SHALL propagate rounding carry: {mant[20],frac}+1 overflowing past bit 10 sets frac=0, exp+=1; a subnormal rounding up into bit 10 yields exponent field 1.
REQ-010 SHALL pack exponent field as exp when mant[20]=1 after rounding, else 0.
REQ-011 SHALL, when final exp>=31, output sign,5'b11111,10'b0 with flag_overflow=1, flag_inexact=1.
REQ-012 SHALL set flag_inexact=G|S; flag_underflow=1 when the pre-rounding result was subnormal (took DENORM path or exited NORM with mant[20]=0) and inexact.
REQ-013 SHALL hold result, flags and out_valid=1 in DONE until out_ready=1, then return to IDLE; no new input is accepted until then.
REQ-014 SHALL have normal-path latency of 3 cycles from transfer to out_valid, plus one cycle per NORM/DENORM shift.

Reset
REQ-015 SHALL, when rst=0 at a clock edge, enter IDLE and clear out_valid, result, all flags and internal registers to 0, abandoning any in-flight operation; in_ready=1 the cycle after reset release.

Configuration
REQ-016 SHALL support macro HALF_FP_FTZ_EN: defined -> any result that would be subnormal (exp<1 after NORM, or mant[20]=0 with exp==1) goes straight to DONE as signed zero with flag_underflow=1, flag_inexact=1, DENORM never entered; undefined -> gradual underflow per REQ-007..REQ-012.

Verification
REQ-017 exp=15, mant=0x100000, sign=0 -> result 0x3C00, flags 0, out_valid 3 cycles after transfer.
REQ-018 exp=15, mant=0x240000 (1.5*1.5) -> 0x4080; exp=15, mant=0x100200 -> 0x3C00 inexact=1; mant=0x100600 -> 0x3C02 inexact=1.
REQ-019 exp=31, mant=0x100000, sign=1 -> 0xFC00, overflow=1, inexact=1.
REQ-020 exp=0, mant=0x100000 -> 0x0200, underflow=0, inexact=0; with HALF_FP_FTZ_EN -> 0x0000, underflow=1.
REQ-021 in_special=1, in_special_val=0x7E00 -> 0x7E00 one cycle later, flags 0; hold out_ready=0 for 5 cycles -> result stable, in_ready=0 throughout.
REQ-022 assert rst=0 mid-DENORM -> next cycle out_valid=0, result=0, in_ready=1 after release.

Source files
------------

// File: rtl/half_fp_round_pack.sv
// Normalise, round (nearest-even) and pack a raw half-precision product into IEEE binary16.
// Build option HALF_FP_FTZ_EN: flush subnormal results to signed zero instead of gradual underflow.
module half_fp_round_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [6:0]  in_exp,
    input  logic [21:0] in_mant,
    input  logic        in_special,
    input  logic [15:0] in_special_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        flag_overflow,
    output logic        flag_underflow,
    output logic        flag_inexact
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] NORM   = 3'd1;
    localparam logic [2:0] DENORM = 3'd2;
    localparam logic [2:0] ROUND  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              sign_q, sign_d;
    logic signed [8:0] exp_q, exp_d;
    logic [21:0]       mant_q, mant_d;
    logic              sticky_q, sticky_d;
    logic              sub_q, sub_d;
    logic [15:0]       result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              inx_q, inx_d;

    logic [9:0]        frac;
    logic              guard;
    logic              rest;
    logic              inc;
    logic [11:0]       sum;
    logic              hidden;
    logic signed [8:0] exp_rnd;

    // Round-to-nearest-even on the current mantissa; sum[11] is the carry out of the hidden bit.
    always_comb begin
        frac    = mant_q[19:10];
        guard   = mant_q[9];
        rest    = (|mant_q[8:0]) | sticky_q;
        inc     = guard & (rest | frac[0]);
        sum     = {1'b0, mant_q[20], frac} + {11'b0, inc};
        hidden  = sum[11] | sum[10];
        exp_rnd = sum[11] ? exp_q + 9'sd1 : exp_q;
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        sticky_d = sticky_q;
        sub_d    = sub_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d   = in_sign;
                    exp_d    = {{2{in_exp[6]}}, in_exp};
                    mant_d   = in_mant;
                    sticky_d = 1'b0;
                    sub_d    = 1'b0;
                    if (in_special) begin
                        result_d = in_special_val;
                        ovf_d    = 1'b0;
                        unf_d    = 1'b0;
                        inx_d    = 1'b0;
                        state_d  = DONE;
                    end else begin
                        state_d  = NORM;
                    end
                end
            end
            NORM: begin
                if (mant_q == 22'd0) begin
                    result_d = {sign_q, 15'd0};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    inx_d    = 1'b0;
                    state_d  = DONE;
                end else if (mant_q[21]) begin
                    mant_d   = {1'b0, mant_q[21:1]};
                    sticky_d = sticky_q | mant_q[0];
                    exp_d    = exp_q + 9'sd1;
                end else if (!mant_q[20] && exp_q > 9'sd1) begin
                    mant_d   = {mant_q[20:0], 1'b0};
                    exp_d    = exp_q - 9'sd1;
                end else begin
`ifdef HALF_FP_FTZ_EN
                    if (exp_q < 9'sd1 || !mant_q[20]) begin
                        result_d = {sign_q, 15'd0};
                        ovf_d    = 1'b0;
                        unf_d    = 1'b1;
                        inx_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d  = ROUND;
                    end
`else
                    if (exp_q < 9'sd1) begin
                        sub_d   = 1'b1;
                        state_d = DENORM;
                    end else begin
                        sub_d   = !mant_q[20];
                        state_d = ROUND;
                    end
`endif
                end
            end
            DENORM: begin
                // Far below the subnormal range only the sticky information survives.
                if (exp_q < -9'sd11) begin
                    mant_d   = 22'd0;
                    sticky_d = sticky_q | (|mant_q);
                    exp_d    = 9'sd1;
                    state_d  = ROUND;
                end else begin
                    mant_d   = {1'b0, mant_q[21:1]};
                    sticky_d = sticky_q | mant_q[0];
                    exp_d    = exp_q + 9'sd1;
                    if (exp_q == 9'sd0) begin
                        state_d = ROUND;
                    end
                end
            end
            ROUND: begin
                if (exp_rnd >= 9'sd31) begin
                    result_d = {sign_q, 5'h1f, 10'd0};
                    ovf_d    = 1'b1;
                    unf_d    = 1'b0;
                    inx_d    = 1'b1;
                end else begin
                    result_d = {sign_q, (hidden ? exp_rnd[4:0] : 5'd0), sum[9:0]};
                    ovf_d    = 1'b0;
                    unf_d    = sub_q & (guard | rest);
                    inx_d    = guard | rest;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= 9'sd0;
            mant_q   <= 22'd0;
            sticky_q <= 1'b0;
            sub_q    <= 1'b0;
            result_q <= 16'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            sticky_q <= sticky_d;
            sub_q    <= sub_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign out_valid      = (state_q == DONE);
    assign result         = result_q;
    assign flag_overflow  = ovf_q;
    assign flag_underflow = unf_q;
    assign flag_inexact   = inx_q;

endmodule

// File: tb/tb_half_fp_round_pack.sv
// Self-checking bench for half_fp_round_pack: directed corner cases plus random products
// compared with an exact round-to-nearest-even binary16 model.
module tb_half_fp_round_pack;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [6:0]  in_exp;
    logic [21:0] in_mant;
    logic        in_special;
    logic [15:0] in_special_val;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;

    int checks = 0;
    int errors = 0;

    half_fp_round_pack dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .in_special    (in_special),
        .in_special_val(in_special_val),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .flag_overflow (flag_overflow),
        .flag_underflow(flag_underflow),
        .flag_inexact  (flag_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        int          e;
        logic [21:0] m;
        logic [18:0] expv;
        int          lat;
    } vec_t;

    // Exact value is m * 2^(e-35); round it to binary16 with tininess detected before rounding.
    // Returns {overflow, underflow, inexact, result}.
    function automatic logic [18:0] ref_model(input logic sg, input int e, input longint m,
                                              input logic sp, input logic [15:0] sv);
        int     p;
        int     be;
        int     k;
        longint n;
        longint rem;
        longint half;
        logic   tiny;
        logic   inx;
        logic [15:0] r;
        if (sp) return {3'b000, sv};
        if (m == 0) return {3'b000, sg, 15'd0};
        p = 0;
        for (int i = 0; i < 22; i++) if (((m >> i) & 1) != 0) p = i;
        be   = p + e - 20;
        tiny = (be < 1);
`ifdef HALF_FP_FTZ_EN
        if (tiny) return {3'b011, sg, 15'd0};
`endif
        k = tiny ? (11 - e) : (p - 10);
        if (k <= 0) begin
            n   = m << (-k);
            inx = 1'b0;
        end else if (k >= 40) begin
            n   = 0;
            inx = 1'b1;
        end else begin
            n    = m >> k;
            rem  = m & ((64'sd1 << k) - 1);
            half = 64'sd1 << (k - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && n[0])) n = n + 1;
        end
        if (tiny) begin
            r = {sg, n[14:0]};
        end else begin
            if (n == 2048) begin
                n  = 1024;
                be = be + 1;
            end
            if (be >= 31) return {3'b101, sg, 5'h1f, 10'd0};
            r = {sg, be[4:0], n[9:0]};
        end
        return {1'b0, tiny & inx, inx, r};
    endfunction

    // Drives one transfer, waits for the result and accepts it; lat counts edges from transfer.
    task automatic run_op(input logic sg, input int e, input logic [21:0] m, input logic sp,
                          input logic [15:0] sv, input logic early_rdy,
                          output logic [18:0] got, output int lat);
        int n;
        in_sign        = sg;
        in_exp         = e[6:0];
        in_mant        = m;
        in_special     = sp;
        in_special_val = sv;
        out_ready      = early_rdy;
        in_valid       = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = {flag_overflow, flag_underflow, flag_inexact, result};
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b required 0", out_valid);
        end
        checks++;
        if ({flag_overflow, flag_underflow, flag_inexact, result} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {flag_overflow, flag_underflow, flag_inexact, result});
        end
    endtask

    task automatic test_directed();
        vec_t        v[$];
        logic [18:0] got;
        int          lat;
        v.push_back('{1'b0, 15, 22'h100000, 19'h03C00, 3});
        v.push_back('{1'b0, 15, 22'h240000, 19'h04080, 4});
        v.push_back('{1'b0, 15, 22'h100200, 19'h13C00, 3});
        v.push_back('{1'b0, 15, 22'h100600, 19'h13C02, 3});
        v.push_back('{1'b1, 31, 22'h100000, 19'h5FC00, 3});
        v.push_back('{1'b0, 30, 22'h1FFE00, 19'h57C00, 3});
        v.push_back('{1'b0, 30, 22'h1FFC00, 19'h07BFF, 3});
        v.push_back('{1'b1, 10, 22'h000000, 19'h08000, 2});
`ifdef HALF_FP_FTZ_EN
        v.push_back('{1'b0, 0, 22'h100000, 19'h30000, 2});
        v.push_back('{1'b0, 1, 22'h0FFE00, 19'h30000, 2});
`else
        v.push_back('{1'b0, 0, 22'h100000, 19'h00200, 4});
        v.push_back('{1'b0, 1, 22'h0FFE00, 19'h30400, 3});
`endif
        foreach (v[i]) begin
            run_op(v[i].sg, v[i].e, v[i].m, 1'b0, 16'h0, 1'b0, got, lat);
            checks++;
            if (got !== v[i].expv) begin
                errors++;
                $display("FAIL directed_%0d_value: got %h required %h", i, got, v[i].expv);
            end
            checks++;
            if (lat !== v[i].lat) begin
                errors++;
                $display("FAIL directed_%0d_latency: got %0d required %0d", i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_special_hold();
        in_sign        = 1'b0;
        in_exp         = 7'd0;
        in_mant        = 22'h100000;
        in_special     = 1'b1;
        in_special_val = 16'h7E00;
        out_ready      = 1'b0;
        in_valid       = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_special = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if ({out_valid, in_ready, flag_overflow, flag_underflow, flag_inexact, result}
                !== {2'b10, 3'b000, 16'h7E00}) begin
                errors++;
                $display("FAIL special_hold_%0d: got valid=%b ready=%b flags=%b%b%b res=%h required valid=1 ready=0 flags=000 res=7e00",
                         c, out_valid, in_ready, flag_overflow, flag_underflow, flag_inexact,
                         result);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL special_release: got valid=%b ready=%b required valid=0 ready=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_denorm();
        logic [18:0] got;
        int          lat;
        in_sign    = 1'b1;
        in_exp     = 7'h7B;  // -5: six DENORM shifts follow
        in_mant    = 22'h100000;
        in_special = 1'b0;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, result, flag_overflow, flag_underflow, flag_inexact} !== 20'd0) begin
            errors++;
            $display("FAIL mid_reset_clear: got valid=%b res=%h flags=%b%b%b required all 0",
                     out_valid, result, flag_overflow, flag_underflow, flag_inexact);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready: got %b required 1", in_ready);
        end
        run_op(1'b0, 16, 22'h180000, 1'b0, 16'h0, 1'b0, got, lat);
        checks++;
        if (got !== ref_model(1'b0, 16, 64'h180000, 1'b0, 16'h0)) begin
            errors++;
            $display("FAIL mid_reset_recover: got %h required %h", got,
                     ref_model(1'b0, 16, 64'h180000, 1'b0, 16'h0));
        end
    endtask

    task automatic test_random(input int count, input logic back_to_back);
        logic [18:0] got;
        logic [18:0] expv;
        logic [21:0] m;
        logic        sg;
        logic        sp;
        logic [15:0] sv;
        int          e;
        int          lat;
        int unsigned m1;
        int unsigned m2;
        for (int i = 0; i < count; i++) begin
            sg = 1'($urandom_range(0, 1));
            m1 = $urandom_range(0, 1023);
            m2 = $urandom_range(0, 1023);
            case ($urandom_range(0, 3))
                0, 1: m = 22'((1024 + m1) * (1024 + m2));
                2:    m = 22'(m1 * (1024 + m2));
                default: m = 22'($urandom >> $urandom_range(10, 31));
            endcase
            if ($urandom_range(0, 1) == 1) e = int'($urandom_range(0, 45)) - 10;
            else e = int'($urandom_range(0, 127)) - 64;
            sp = ($urandom_range(0, 15) == 0);
            sv = 16'($urandom);
            expv = ref_model(sg, e, longint'(m), sp, sv);
            run_op(sg, e, m, sp, sv, back_to_back | 1'($urandom_range(0, 1)), got, lat);
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL random_%0d sg=%b e=%0d m=%h sp=%b: got %h required %h",
                         i, sg, e, m, sp, got, expv);
            end
        end
    endtask

    initial begin
        rst            = 1'b0;
        in_valid       = 1'b0;
        in_sign        = 1'b0;
        in_exp         = 7'd0;
        in_mant        = 22'd0;
        in_special     = 1'b0;
        in_special_val = 16'd0;
        out_ready      = 1'b0;
        test_reset();
        test_directed();
        test_special_hold();
        test_reset_mid_denorm();
        test_random(300, 1'b0);
        test_random(60, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
